// File: rtl/hazard_ctrl.sv
// Hazard detection, stall/flush control and forwarding selects for a 5-stage pipe.
// Define HAZARD_FORWARD_EN to forward results and stall only on load-use.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_reg_write,
  input  logic        id_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_stall,
  output logic        stall_if,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        freeze,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } shadow_t;

  shadow_t ex_q;
  shadow_t mem_q;
  shadow_t wb_q;

  logic wr_ex;
  logic wr_mem;
  logic wr_wb;
  logic a_ex;
  logic a_mem;
  logic a_wb;
  logic b_ex;
  logic b_mem;
  logic b_wb;
  logic hazard;
  logic active;
  logic unused_shadow;

  // x0 is never a producer, so it can neither stall nor forward
  assign wr_ex  = ex_q.valid  & ex_q.reg_write  & (ex_q.rd  != 5'd0);
  assign wr_mem = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0);
  assign wr_wb  = wb_q.valid  & wb_q.reg_write  & (wb_q.rd  != 5'd0);

  assign a_ex  = id_valid & id_uses_rs1 & wr_ex
               & (id_rs1_addr == ex_q.rd);
  assign a_mem = id_valid & id_uses_rs1 & wr_mem
               & (id_rs1_addr == mem_q.rd);
  assign a_wb  = id_valid & id_uses_rs1 & wr_wb
               & (id_rs1_addr == wb_q.rd);
  assign b_ex  = id_valid & id_uses_rs2 & wr_ex
               & (id_rs2_addr == ex_q.rd);
  assign b_mem = id_valid & id_uses_rs2 & wr_mem
               & (id_rs2_addr == mem_q.rd);
  assign b_wb  = id_valid & id_uses_rs2 & wr_wb
               & (id_rs2_addr == wb_q.rd);

`ifdef HAZARD_FORWARD_EN
  assign hazard = (a_ex | b_ex) & ex_q.is_load;
`else
  assign hazard = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
`endif

  assign active    = rst_n & ~mem_stall;
  assign freeze    = mem_stall;
  assign flush_id  = active & ex_branch_taken;
  assign stall_if  = active & ~ex_branch_taken & hazard;
  assign bubble_ex = active & (ex_branch_taken | hazard);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else if (!mem_stall) begin
      wb_q            <= mem_q;
      mem_q           <= ex_q;
      ex_q.valid      <= id_valid & ~bubble_ex;
      ex_q.rd         <= id_rd_addr;
      ex_q.reg_write  <= id_reg_write;
      ex_q.is_load    <= id_is_load;
      if (stall_if && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_q;
  logic [1:0] fwd_b_q;

  // youngest producer wins
  function automatic logic [1:0] pick(
    input logic m_ex,
    input logic m_mem,
    input logic m_wb
  );
    logic [1:0] s;
    s = 2'b00;
    if (m_ex)
      s = 2'b01;
    else if (m_mem)
      s = 2'b10;
    else if (m_wb)
      s = 2'b11;
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (!mem_stall) begin
      if (bubble_ex) begin
        fwd_a_q <= 2'b00;
        fwd_b_q <= 2'b00;
      end else begin
        fwd_a_q <= pick(a_ex, a_mem, a_wb);
        fwd_b_q <= pick(b_ex, b_mem, b_wb);
      end
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  assign unused_shadow = ^{ex_q.is_load, wb_q.is_load};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
// Driver queues expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic        id_is_load;
  logic        ex_branch_taken;
  logic        mem_stall;
  logic        stall_if;
  logic        bubble_ex;
  logic        flush_id;
  logic        freeze;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [15:0] stall_cnt;

  hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd_addr      (id_rd_addr),
    .id_reg_write    (id_reg_write),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_stall       (mem_stall),
    .stall_if        (stall_if),
    .bubble_ex       (bubble_ex),
    .flush_id        (flush_id),
    .freeze          (freeze),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } id_t;

  typedef struct packed {
    logic        s;
    logic        b;
    logic        f;
    logic        fz;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_t;
  exp_t mon_a;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic id_t mkid(
    input logic v, input logic [4:0] rs1, input logic u1,
    input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd, input logic rw, input logic ld);
    id_t i;
    i.v = v; i.rs1 = rs1; i.u1 = u1;
    i.rs2 = rs2; i.u2 = u2;
    i.rd = rd; i.rw = rw; i.ld = ld;
    return i;
  endfunction

  function automatic id_t op(
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2);
    return mkid(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0);
  endfunction

  function automatic id_t lw(
    input logic [4:0] rd, input logic [4:0] rs1);
    return mkid(1'b1, rs1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1);
  endfunction

  function automatic id_t nop();
    return mkid(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  task automatic apply(input id_t i, input logic br,
                       input logic ms, input logic rn);
    id_valid        = i.v;
    id_rs1_addr     = i.rs1;
    id_uses_rs1     = i.u1;
    id_rs2_addr     = i.rs2;
    id_uses_rs2     = i.u2;
    id_rd_addr      = i.rd;
    id_reg_write    = i.rw;
    id_is_load      = i.ld;
    ex_branch_taken = br;
    mem_stall       = ms;
    rst_n           = rn;
  endtask

  task automatic cyc(
    input string nm, input id_t i,
    input logic br, input logic ms, input logic rn,
    input logic s, input logic b, input logic f,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [15:0] cnt);
    sb_t t;
    @(posedge clk);
    #1;
    apply(i, br, ms, rn);
    t.name = nm;
    t.e    = {s, b, f, ms, fa, fb, cnt};
    sb_q.push_back(t);
  endtask

  task automatic idle(input int n, input logic [15:0] cnt);
    repeat (n)
      cyc("idle", nop(), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, cnt);
  endtask

  task automatic quiet(input id_t i, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      apply(i, 1'b0, 1'b0, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_t = sb_q.pop_front();
      mon_a = {stall_if, bubble_ex, flush_id, freeze,
               fwd_a_sel, fwd_b_sel, stall_cnt};
      n_chk++;
      if (mon_a !== mon_t.e) begin
        n_fail++;
        $display("FAIL %s: got s/b/f/fz=%b%b%b%b fa=%b fb=%b cnt=%h, want s/b/f/fz=%b%b%b%b fa=%b fb=%b cnt=%h",
                 mon_t.name, mon_a.s, mon_a.b, mon_a.f, mon_a.fz,
                 mon_a.fa, mon_a.fb, mon_a.cnt,
                 mon_t.e.s, mon_t.e.b, mon_t.e.f, mon_t.e.fz,
                 mon_t.e.fa, mon_t.e.fb, mon_t.e.cnt);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    apply(nop(), 1'b0, 1'b0, 1'b0);
    cyc("rst_a", nop(), 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
    cyc("rst_b", lw(5, 1), 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
    idle(1, 16'd0);

`ifdef HAZARD_FORWARD_EN
    cyc("lu_prod", lw(5, 1),    0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd0);
    cyc("lu_stall", op(6, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd0);
    cyc("lu_go",   op(6, 5, 1), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("lu_fwd",  nop(),       0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 16'd1);
    idle(3, 16'd1);

    cyc("ex_prod", op(5, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("ex_use",  op(7, 1, 5), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("ex_fwd",  nop(),       0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 16'd1);
    idle(3, 16'd1);

    cyc("wb_prod", op(5, 1, 2),  0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("wb_ind1", op(10, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("wb_ind2", op(11, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("wb_use",  op(7, 1, 5),  0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("wb_fwd",  nop(),        0, 0, 1, 0, 0, 0, 2'b00, 2'b11, 16'd1);
    idle(3, 16'd1);

    cyc("br_prod",  lw(5, 1),    0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("br_flush", op(6, 5, 1), 1, 0, 1, 0, 1, 1, 2'b00, 2'b00, 16'd1);
    cyc("br_after", nop(),       0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    idle(3, 16'd1);

    cyc("fz_prod", op(9, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("fz_load", lw(5, 9),    0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd1);
    cyc("fz_h1",   op(6, 5, 1), 0, 1, 1, 0, 0, 0, 2'b01, 2'b00, 16'd1);
    cyc("fz_h2",   op(6, 5, 1), 0, 1, 1, 0, 0, 0, 2'b01, 2'b00, 16'd1);
    cyc("fz_h3",   op(6, 5, 1), 1, 1, 1, 0, 0, 0, 2'b01, 2'b00, 16'd1);
    cyc("fz_stall", op(6, 5, 1), 0, 0, 1, 1, 1, 0, 2'b01, 2'b00, 16'd1);
    cyc("fz_go",   op(6, 5, 1), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd2);
    cyc("fz_fwd",  nop(),       0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 16'd2);
    idle(3, 16'd2);

    cyc("x0_prod", lw(0, 1),    0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd2);
    cyc("x0_use",  op(6, 0, 0), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd2);
    cyc("x0_sel",  nop(),       0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd2);
    idle(3, 16'd2);

    cyc("rs_prod",  lw(5, 1),    0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd2);
    cyc("rs_stall", op(6, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd2);
    cyc("rs_hold",  op(6, 5, 1), 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("rs_after", op(6, 5, 1), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd0);
    idle(3, 16'd0);
`else
    cyc("d1_prod", op(5, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd0);
    cyc("d1_st1",  op(6, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd0);
    cyc("d1_st2",  op(6, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd1);
    cyc("d1_st3",  op(6, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd2);
    cyc("d1_go",   op(6, 5, 1), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    idle(3, 16'd3);

    cyc("x0_prod", op(0, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("x0_use",  op(6, 0, 0), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("nu_prod", op(7, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("nu_read", mkid(1, 7, 0, 7, 0, 8, 1, 0),
        0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("nv_read", mkid(0, 7, 1, 7, 1, 8, 1, 0),
        0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    idle(3, 16'd3);

    cyc("br_prod",  op(7, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("br_flush", op(8, 7, 1), 1, 0, 1, 0, 1, 1, 2'b00, 2'b00, 16'd3);
    cyc("br_after", nop(),       0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    idle(3, 16'd3);

    cyc("fz_prod", op(8, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("fz_h1",   op(9, 8, 1), 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("fz_h2",   op(9, 8, 1), 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("fz_h3",   op(9, 8, 1), 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 16'd3);
    cyc("fz_st1",  op(9, 8, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd3);
    cyc("fz_st2",  op(9, 8, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd4);
    cyc("fz_st3",  op(9, 8, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd5);
    cyc("fz_go",   op(9, 8, 1), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd6);
    idle(3, 16'd6);

    cyc("rs_prod",  op(10, 1, 2), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd6);
    cyc("rs_stall", op(11, 10, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd6);
    cyc("rs_hold",  op(11, 10, 1), 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd7);
    cyc("rs_after", op(11, 10, 1), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'd0);
    idle(3, 16'd0);

    // self-dependent writer: 3 stalls then 1 issue, repeating
    quiet(op(5, 5, 1), 1 + 4 * 21844);
    cyc("sat_fffc", op(5, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'hFFFC);
    cyc("sat_fffd", op(5, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'hFFFD);
    cyc("sat_fffe", op(5, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'hFFFE);
    cyc("sat_ffff", op(5, 5, 1), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      cyc("sat_s1", op(5, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'hFFFF);
      cyc("sat_s2", op(5, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'hFFFF);
      cyc("sat_s3", op(5, 5, 1), 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 16'hFFFF);
      cyc("sat_go", op(5, 5, 1), 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'hFFFF);
    end
`endif

    repeat (2) @(negedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, clk, and a reset, rst_n; reset is synchronous and active-low.
REQ-002 The ports SHALL be, in order:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1_addr, id_rs2_addr  in  5 each  ID source registers
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- id_rd_addr  in  5  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch or jump redirect resolved in EX this cycle
- mem_stall  in  1  data memory not ready; freeze the pipeline
- stall_if  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX instead of the ID instruction
- flush_id  out  1  invalidate the IF/ID instruction
- freeze  out  1  hold every pipeline register
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 regfile, 01 MEM result, 10 WB result, 11 last-written WB data latch
- stall_cnt  out  16  hazard stall cycles counted

Function
REQ-003 The block SHALL keep internal shadow stages EX, MEM and WB, each holding {valid, rd, reg_write, is_load}.
REQ-004 A stage SHALL count as a writer only when valid=1, reg_write=1 and rd≠0; register x0 SHALL never cause a hazard or a forward.
REQ-005 Source s of ID SHALL match stage X when id_valid=1, id_uses_s=1, X is a writer, and id_rs_s_addr equals X.rd.
REQ-006 A load-use hazard SHALL exist when any ID source matches EX and EX.is_load=1.
REQ-007 When a load-use hazard exists and ex_branch_taken=0, the block SHALL assert stall_if=1 and bubble_ex=1 in the same cycle (combinational).
REQ-008 When ex_branch_taken=1, the block SHALL assert flush_id=1 and bubble_ex=1 for one cycle, and SHALL drive stall_if=0. Flush takes priority over any stall.
REQ-009 freeze SHALL equal mem_stall. While freeze=1:
- the shadow stages, forwarding selects and stall_cnt SHALL hold;
- stall_if, bubble_ex and flush_id SHALL be 0.
REQ-010 Each cycle with freeze=0, the shadow stages SHALL advance:
- WB←MEM, MEM←EX;
- EX←ID fields with valid=id_valid&~bubble_ex.
REQ-011 fwd_a_sel and fwd_b_sel SHALL be registered and SHALL advance when freeze=0, so they are valid while the consumer is in EX. Each selects the youngest matching producer, with priority EX→01, MEM→10, WB→11, otherwise 00. They SHALL load 00 when bubble_ex=1.
REQ-012 stall_cnt SHALL increment by 1 on each cycle with stall_if=1 and freeze=0, and SHALL saturate at 16'hFFFF.
REQ-013 Stall and flush outputs SHALL be combinational functions of the current inputs and shadow state, with zero cycles of latency.

Reset
REQ-014 While rst_n=0 at a clk rising edge, the block SHALL clear:
- all shadow valid bits, rd and flags;
- fwd_a_sel and fwd_b_sel to 00;
- stall_cnt to 0.
REQ-015 While rst_n=0, stall_if, bubble_ex and flush_id SHALL be 0.
REQ-016 A reset asserted mid-stall SHALL discard the pending hazard; the first cycle after reset SHALL see no hazard.

Configuration
REQ-017 With macro HAZARD_FORWARD_EN defined, behaviour SHALL be as in REQ-006 to REQ-011, and only load-use hazards stall.
REQ-018 With HAZARD_FORWARD_EN undefined:
- fwd_a_sel and fwd_b_sel SHALL be constant 00;
- a hazard SHALL exist whenever any ID source matches EX, MEM or WB regardless of is_load;
- REQ-007 applies to that hazard, so the stall repeats until no match remains.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Forwarding enabled: lw x5 then add x6,x5,x1 → exactly 1 cycle with stall_if=1 and bubble_ex=1; next cycle fwd_a_sel=10 while add is in EX; stall_cnt=1.
- Forwarding enabled: add x5 then sub x7,x1,x5 back-to-back → no stall; fwd_b_sel=01 with sub in EX. Same case with 2 independent instructions in between → fwd_b_sel=11.
- ex_branch_taken=1 coincident with a load-use hazard → flush_id=1, bubble_ex=1, stall_if=0, and stall_cnt unchanged.
- mem_stall held 3 cycles during a load-use hazard → freeze=1 and stall_if=0 for 3 cycles; shadow state and fwd selects held; the 1-cycle stall occurs after release.
- Writer with rd=x0 followed by a reader of x0 → no stall; sel 00. Forwarding disabled: add x5 then reader of x5 → 3 stall cycles; stall_cnt=3.
- rst_n=0 asserted during a stall cycle → next cycle all outputs 0 and stall_cnt=0. 65540 forced stall cycles → stall_cnt=16'hFFFF.
